// File: rtl/ha_bist_pkg.sv
// Shared types and constants for the half-adder BIST.
// Used by half_adder_bist and ha_golden.
package ha_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int VEC_W  = 2;
    localparam int RESP_W = 2;

    // Reference {carry, sum} for a {a, b} input pair.
    function automatic logic [RESP_W-1:0] ha_ref(input logic [VEC_W-1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/ha_golden.sv
// Combinational golden model of a half adder.
// Maps {a, b} to the expected {c_out, s}.
module ha_golden
    import ha_bist_pkg::*;
(
    input  logic [VEC_W-1:0]  i_vec,
    output logic [RESP_W-1:0] o_resp
);

    assign o_resp = ha_ref(i_vec);

endmodule

// File: rtl/half_adder_bist.sv
// Exhaustive self-test driver/checker for the half_adder cell.
// Optional first-failure log enabled by HA_BIST_ERRLOG_EN.
module half_adder_bist
    import ha_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             c_out,
    input  logic             s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
`ifdef HA_BIST_ERRLOG_EN
    ,
    output logic [3:0]       fail_vec
`endif
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PAS_W = $clog2(PASSES + 1);
    localparam int SET_L = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_L);
    localparam logic [PAS_W-1:0] PAS_LAST = PAS_W'(PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_t              r_state;
    logic [VEC_W-1:0]    r_vec;
    logic [SET_W-1:0]    r_set;
    logic [PAS_W-1:0]    r_pcnt;
    logic [CNT_W-1:0]    r_err;
    logic                r_a;
    logic                r_b;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
`ifdef HA_BIST_ERRLOG_EN
    logic [3:0]          r_fail_vec;
`endif

    logic [RESP_W-1:0]   w_exp;
    logic [RESP_W-1:0]   w_resp;
    logic                w_mis;
    logic [CNT_W-1:0]    w_err_nx;

    ha_golden u_golden (
        .i_vec  ({r_a, r_b}),
        .o_resp (w_exp)
    );

    assign w_resp   = {c_out, s};
    // A mismatch on both bits still counts once.
    assign w_mis    = (w_resp != w_exp);
    assign w_err_nx = (r_err == ERR_MAX) ? r_err : r_err + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_set   <= '0;
            r_pcnt  <= '0;
            r_err   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
`ifdef HA_BIST_ERRLOG_EN
            r_fail_vec <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= APPLY;
                        r_vec   <= '0;
                        r_pcnt  <= '0;
                        r_err   <= '0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
`ifdef HA_BIST_ERRLOG_EN
                        r_fail_vec <= '0;
`endif
                    end
                end
                APPLY: begin
                    {r_a, r_b} <= r_vec;
                    r_set      <= '0;
                    r_state    <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (r_set == SET_LAST) begin
                        r_state <= CHECK;
                    end else begin
                        r_set <= r_set + SET_W'(1);
                    end
                end
                CHECK: begin
                    if (w_mis) begin
                        r_err <= w_err_nx;
`ifdef HA_BIST_ERRLOG_EN
                        // Saturating count never returns to 0 within a run.
                        if (r_err == '0) begin
                            r_fail_vec <= {r_a, r_b, c_out, s};
                        end
`endif
                    end
                    r_vec   <= r_vec + VEC_W'(1);
                    r_state <= APPLY;
                    if (r_vec == 2'd3) begin
                        if (r_pcnt == PAS_LAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err == '0) && !w_mis;
                        end else begin
                            r_pcnt <= r_pcnt + PAS_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;
`ifdef HA_BIST_ERRLOG_EN
    assign fail_vec = r_fail_vec;
`endif

endmodule

// File: tb/tb_half_adder_bist.sv
// Bench for half_adder_bist: four parameterisations, each wired
// to a half-adder model with injectable stuck-at faults.
module tb_half_adder_bist;

    localparam int SC [4] = '{2, 0, 1, 2};
    localparam int PS [4] = '{1, 3, 2, 2};
    localparam int CW [4] = '{8, 8, 2, 8};

    typedef struct {
        int         cyc;
        int         err;
        int         ps;
        logic [3:0] fv;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start;
    logic [3:0] va, vb, vc, vs;
    logic [3:0] busy, done, pass;
    logic [7:0] err [4];
    logic [1:0] err_c;
    logic [3:0] fv [4];
    int         fault [4];

    int   checks = 0;
    int   errors = 0;
    int   q_vec [$];
    res_t q_res [$];

    always #5 clk = ~clk;

    // Half-adder under test: 1 = sum stuck-at-0, 2 = carry stuck-at-1.
    always_comb begin
        vc = '0;
        vs = '0;
        for (int i = 0; i < 4; i++) begin
            vc[i] = va[i] & vb[i];
            vs[i] = va[i] ^ vb[i];
            if (fault[i] == 1) vs[i] = 1'b0;
            if (fault[i] == 2) vc[i] = 1'b1;
        end
    end

    assign err[2] = {6'b0, err_c};

`ifndef HA_BIST_ERRLOG_EN
    assign fv[0] = '0;
    assign fv[1] = '0;
    assign fv[2] = '0;
    assign fv[3] = '0;
`endif

    half_adder_bist #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a(va[0]), .b(vb[0]), .c_out(vc[0]), .s(vs[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err[0])
`ifdef HA_BIST_ERRLOG_EN
        , .fail_vec(fv[0])
`endif
    );

    half_adder_bist #(.SETTLE_CYCLES(0), .PASSES(3), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a(va[1]), .b(vb[1]), .c_out(vc[1]), .s(vs[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err[1])
`ifdef HA_BIST_ERRLOG_EN
        , .fail_vec(fv[1])
`endif
    );

    half_adder_bist #(.SETTLE_CYCLES(1), .PASSES(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .a(va[2]), .b(vb[2]), .c_out(vc[2]), .s(vs[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_cnt(err_c)
`ifdef HA_BIST_ERRLOG_EN
        , .fail_vec(fv[2])
`endif
    );

    half_adder_bist #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start[3]),
        .a(va[3]), .b(vb[3]), .c_out(vc[3]), .s(vs[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_cnt(err[3])
`ifdef HA_BIST_ERRLOG_EN
        , .fail_vec(fv[3])
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected error count and first failing {a,b,c,s} for instance i.
    task automatic model(input int i, output int e, output logic [3:0] f);
        logic ra, rb, rc, rs;
        int   mx;
        e = 0;
        f = '0;
        for (int p = 0; p < PS[i]; p++) begin
            for (int v = 0; v < 4; v++) begin
                ra = v[1];
                rb = v[0];
                rc = ra & rb;
                rs = ra ^ rb;
                if (fault[i] == 1) rs = 1'b0;
                if (fault[i] == 2) rc = 1'b1;
                if (rc != (ra & rb) || rs != (ra ^ rb)) begin
                    if (e == 0) f = {ra, rb, rc, rs};
                    e++;
                end
            end
        end
        mx = (1 << CW[i]) - 1;
        if (e > mx) e = mx;
    endtask

    task automatic run(input int i, input bit poke);
        res_t r;
        int   len, n, lim, ev;
        len = SC[i] + 2;
        model(i, r.err, r.fv);
        r.cyc = 4 * PS[i] * len + 1;
        r.ps  = (r.err == 0) ? 1 : 0;
        q_res.push_back(r);
        for (int p = 0; p < PS[i]; p++)
            for (int v = 0; v < 4; v++) q_vec.push_back(v);
        lim = r.cyc + 20;
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        n = 1;
        chk($sformatf("busy_rise%0d", i), int'(busy[i]), 1);
        chk($sformatf("err_clr%0d", i), int'(err[i]), 0);
        chk($sformatf("done_clr%0d", i), int'(done[i]), 0);
        while (!done[i] && n < lim) begin
            if (n % len == 0 && q_vec.size() > 0) begin
                ev = q_vec.pop_front();
                chk($sformatf("vec%0d_n%0d", i, n), int'({va[i], vb[i]}), ev);
            end
            if (poke && n == 5) start[i] = 1'b1;
            if (poke && n == 6) start[i] = 1'b0;
            @(negedge clk);
            n++;
        end
        r = q_res.pop_front();
        if (!done[i]) chk($sformatf("timeout%0d", i), 0, 1);
        chk($sformatf("done_cyc%0d", i), n, r.cyc);
        chk($sformatf("vecs_left%0d", i), q_vec.size(), 0);
        q_vec.delete();
        chk($sformatf("busy_fall%0d", i), int'(busy[i]), 0);
        chk($sformatf("err_cnt%0d", i), int'(err[i]), r.err);
        chk($sformatf("pass%0d", i), int'(pass[i]), r.ps);
`ifdef HA_BIST_ERRLOG_EN
        chk($sformatf("fail_vec%0d", i), int'(fv[i]), int'(r.fv));
`endif
        repeat (3) @(negedge clk);
        chk($sformatf("hold_done%0d", i), int'(done[i]), 1);
        chk($sformatf("hold_ab%0d", i), int'({va[i], vb[i]}), 3);
        chk($sformatf("hold_err%0d", i), int'(err[i]), r.err);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_ab%0d", tag, i), int'({va[i], vb[i]}), 0);
            chk($sformatf("%s_bdp%0d", tag, i),
                int'({busy[i], done[i], pass[i]}), 0);
            chk($sformatf("%s_err%0d", tag, i), int'(err[i]), 0);
            chk($sformatf("%s_fv%0d", tag, i), int'(fv[i]), 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 4; i++) fault[i] = 0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        run(0, 1'b0);
        run(0, 1'b1);
        run(0, 1'b0);

        fault[3] = 1;
        run(3, 1'b0);
        fault[3] = 0;
        run(3, 1'b0);

        run(1, 1'b0);

        fault[2] = 2;
        run(2, 1'b0);

        // Abort instance 0 during SETTLE of vector 10.
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_ab", int'({va[0], vb[0]}), 2);
        chk("pre_rst_busy", int'(busy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        @(negedge clk);
        run(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
